// File: rtl/cache_tagv_array.sv
// Tag/valid array for a set-associative cache.
// Per-way tag and valid RAMs (no reset), one-cycle registered read with
// write-first bypass, per-way hit compare, and a sweep FSM that zeroes every
// set on reset (INIT) and on an invalidate-all request (CLEAR).
module cache_tagv_array #(
  parameter int TAG_WIDTH   = 20,
  parameter int INDEX_WIDTH = 6,
  parameter int WAYS        = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [INDEX_WIDTH-1:0]      raddr,
  input  logic [TAG_WIDTH-1:0]        rtag,
  input  logic                        we,
  input  logic [INDEX_WIDTH-1:0]      waddr,
  input  logic [WAYS-1:0]             wway,
  input  logic [TAG_WIDTH-1:0]        wtag,
  input  logic                        wvalid,
  input  logic                        inv_req,
  output logic                        busy,
  output logic [WAYS*TAG_WIDTH-1:0]   rd_tag,
  output logic [WAYS-1:0]             rd_valid,
  output logic [WAYS-1:0]             hit,
  output logic                        hit_any
);

  localparam int SETS = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_SET = INDEX_WIDTH'(SETS - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                         r_state;
  logic [INDEX_WIDTH-1:0]         r_cnt;
  logic                           r_busy;

  // Storage: one tag RAM and one valid RAM per way, deliberately not reset.
  logic [TAG_WIDTH-1:0]           r_tag_mem   [WAYS][SETS];
  logic                           r_valid_mem [WAYS][SETS];

  // Read-side registers.
  logic [WAYS-1:0][TAG_WIDTH-1:0] r_rd_tag;
  logic [WAYS-1:0]                r_rd_valid;
  logic [TAG_WIDTH-1:0]           r_rtag;

  // Shared RAM write port (sweep or user write).
  logic [WAYS-1:0]                w_mem_we;
  logic [INDEX_WIDTH-1:0]         w_mem_addr;
  logic [TAG_WIDTH-1:0]           w_mem_tag;
  logic                           w_mem_valid;

  logic [WAYS-1:0][TAG_WIDTH-1:0] w_rd_tag_nxt;
  logic [WAYS-1:0]                w_rd_valid_nxt;
  logic [WAYS-1:0]                w_hit;

  // Sweep FSM: INIT/CLEAR walk every set once, IDLE accepts invalidate requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT, ST_CLEAR: begin
          if (r_cnt == LAST_SET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (inv_req) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Write-port mux: the sweep owns the RAMs while busy; user writes are dropped then.
  always_comb begin
    w_mem_we    = '0;
    w_mem_addr  = waddr;
    w_mem_tag   = wtag;
    w_mem_valid = wvalid;
    if (r_busy) begin
      w_mem_we    = {WAYS{1'b1}};
      w_mem_addr  = r_cnt;
      w_mem_tag   = '0;
      w_mem_valid = 1'b0;
    end else if (we) begin
      w_mem_we    = wway;
    end else begin
      w_mem_we    = '0;
    end
  end

  // RAM write: each way written independently under its own enable.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (w_mem_we[w]) begin
        r_tag_mem[w][w_mem_addr]   <= w_mem_tag;
        r_valid_mem[w][w_mem_addr] <= w_mem_valid;
      end
    end
  end

  // Next read data: zero while sweeping, otherwise write-first bypass over the RAM.
  always_comb begin
    w_rd_tag_nxt   = '0;
    w_rd_valid_nxt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_busy) begin
        w_rd_tag_nxt[w]   = '0;
        w_rd_valid_nxt[w] = 1'b0;
      end else if (w_mem_we[w] && (w_mem_addr == raddr)) begin
        w_rd_tag_nxt[w]   = w_mem_tag;
        w_rd_valid_nxt[w] = w_mem_valid;
      end else begin
        w_rd_tag_nxt[w]   = r_tag_mem[w][raddr];
        w_rd_valid_nxt[w] = r_valid_mem[w][raddr];
      end
    end
  end

  // Read registers: capture the lookup tag and the selected set's contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_tag   <= '0;
      r_rd_valid <= '0;
      r_rtag     <= '0;
    end else begin
      r_rd_tag   <= w_rd_tag_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rtag     <= rtag;
    end
  end

  // Hit compare: full-width equality of registered tags, qualified by valid.
  always_comb begin
    w_hit = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_rd_valid[w] && (r_rd_tag[w] == r_rtag)) begin
        w_hit[w] = 1'b1;
      end else begin
        w_hit[w] = 1'b0;
      end
    end
  end

  assign busy     = r_busy;
  assign rd_tag   = r_rd_tag;
  assign rd_valid = r_rd_valid;
  assign hit      = w_hit;
  assign hit_any  = |w_hit;

endmodule

// File: tb/tb_cache_tagv_array.sv
// Self-checking bench for cache_tagv_array at default parameters.
// A set-level model (plain arrays plus a sweep countdown) predicts every
// cycle's outputs; a constant table and directed sequences add fixed checks.
module tb_cache_tagv_array;

  localparam int TW   = 20;
  localparam int IW   = 6;
  localparam int NW   = 2;
  localparam int SETS = 64;

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic [IW-1:0]  raddr = '0;
  logic [TW-1:0]  rtag = '0;
  logic           we = 1'b0;
  logic [IW-1:0]  waddr = '0;
  logic [NW-1:0]  wway = '0;
  logic [TW-1:0]  wtag = '0;
  logic           wvalid = 1'b0;
  logic           inv_req = 1'b0;
  logic           busy;
  logic [NW*TW-1:0] rd_tag;
  logic [NW-1:0]  rd_valid;
  logic [NW-1:0]  hit;
  logic           hit_any;

  cache_tagv_array #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .WAYS(NW)) dut (
    .clk(clk), .rstn(rstn), .raddr(raddr), .rtag(rtag), .we(we),
    .waddr(waddr), .wway(wway), .wtag(wtag), .wvalid(wvalid),
    .inv_req(inv_req), .busy(busy), .rd_tag(rd_tag), .rd_valid(rd_valid),
    .hit(hit), .hit_any(hit_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [IW-1:0] waddr;
    logic [NW-1:0] wway;
    logic [TW-1:0] wtag;
    logic          wvalid;
    logic [IW-1:0] raddr;
    logic [TW-1:0] rtag;
    logic          inv;
    logic [NW-1:0] exp_hit;
    logic [NW-1:0] exp_valid;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: contents per way/set, and edges left until the sweep finishes.
  logic [TW-1:0] m_tag [NW][SETS];
  logic          m_val [NW][SETS];
  int            m_left;
  logic [NW-1:0] m_rd_valid;
  logic [NW-1:0] m_hit;
  logic [TW-1:0] m_rd_tag [NW];
  logic          m_read_ok;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < NW; w++)
      for (int s = 0; s < SETS; s++) begin
        m_tag[w][s] = '0;
        m_val[w][s] = 1'b0;
      end
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v.we = 1'b0; v.waddr = '0; v.wway = '0; v.wtag = '0; v.wvalid = 1'b0;
    v.raddr = '0; v.rtag = '0; v.inv = 1'b0; v.exp_hit = '0; v.exp_valid = '0;
    return v;
  endfunction

  function automatic vec_t wr_vec(input logic [IW-1:0] a, input logic [NW-1:0] ways,
                                  input logic [TW-1:0] t, input logic v_bit);
    vec_t v;
    v = idle_vec();
    v.we = 1'b1; v.waddr = a; v.wway = ways; v.wtag = t; v.wvalid = v_bit;
    return v;
  endfunction

  function automatic vec_t rd_vec(input logic [IW-1:0] a, input logic [TW-1:0] t);
    vec_t v;
    v = idle_vec();
    v.raddr = a; v.rtag = t;
    return v;
  endfunction

  // One clock: drive, advance the model by one edge, compare all outputs.
  task automatic step(input vec_t v);
    we = v.we; waddr = v.waddr; wway = v.wway; wtag = v.wtag; wvalid = v.wvalid;
    raddr = v.raddr; rtag = v.rtag; inv_req = v.inv;
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      m_read_ok  = 1'b0;
      m_rd_valid = '0;
      m_hit      = '0;
    end else begin
      if (v.we)
        for (int w = 0; w < NW; w++)
          if (v.wway[w]) begin
            m_tag[w][v.waddr] = v.wtag;
            m_val[w][v.waddr] = v.wvalid;
          end
      for (int w = 0; w < NW; w++) begin
        m_rd_tag[w]   = m_tag[w][v.raddr];
        m_rd_valid[w] = m_val[w][v.raddr];
        m_hit[w]      = m_val[w][v.raddr] && (m_tag[w][v.raddr] == v.rtag);
      end
      m_read_ok = 1'b1;
      if (v.inv) begin
        model_clear();
        m_left = SETS;
      end
    end
    #1;
    chk("busy", 64'(busy), 64'(m_left > 0));
    chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    chk("hit", 64'(hit), 64'(m_hit));
    chk("hit_any", 64'(hit_any), 64'(|m_hit));
    if (m_read_ok)
      for (int w = 0; w < NW; w++)
        chk($sformatf("rd_tag%0d", w), 64'(rd_tag[w*TW +: TW]), 64'(m_rd_tag[w]));
  endtask

  // Idle cycles until busy drops; returns edges taken (optionally re-pulsing inv_req).
  task automatic run_sweep(input int repulse_at, output int cycles);
    vec_t v;
    cycles = 0;
    for (int i = 0; i < 300; i++) begin
      v = idle_vec();
      v.inv = (cycles == repulse_at);
      if (cycles == 10) v = wr_vec(6'd7, 2'b11, 20'h0BEEF, 1'b1);
      step(v);
      cycles++;
      if (!busy) break;
    end
  endtask

  function automatic logic [TW-1:0] pick_tag();
    logic [TW-1:0] pool [4];
    pool[0] = 20'h00000; pool[1] = 20'h00001; pool[2] = 20'hABCDE; pool[3] = 20'hFFFFF;
    return pool[$urandom_range(0, 3)];
  endfunction

  function automatic logic [IW-1:0] pick_addr();
    logic [IW-1:0] pool [4];
    pool[0] = 6'd0; pool[1] = 6'd1; pool[2] = 6'd5; pool[3] = 6'd63;
    return pool[$urandom_range(0, 3)];
  endfunction

  vec_t tbl [8];
  vec_t v;
  int   cyc;

  initial begin
    // Constant-expectation vectors, applied after the initial sweep.
    tbl[0] = wr_vec(6'd5, 2'b10, 20'hABCDE, 1'b1); tbl[0].raddr = 6'd0;
    tbl[0].exp_hit = 2'b00; tbl[0].exp_valid = 2'b00;
    tbl[1] = rd_vec(6'd5, 20'hABCDE); tbl[1].exp_hit = 2'b10; tbl[1].exp_valid = 2'b10;
    tbl[2] = wr_vec(6'd9, 2'b01, 20'h12345, 1'b1); tbl[2].raddr = 6'd9; tbl[2].rtag = 20'h12345;
    tbl[2].exp_hit = 2'b01; tbl[2].exp_valid = 2'b01;
    tbl[3] = rd_vec(6'd5, 20'hABCDF); tbl[3].exp_hit = 2'b00; tbl[3].exp_valid = 2'b10;
    tbl[4] = wr_vec(6'd5, 2'b01, 20'hABCDE, 1'b0); tbl[4].raddr = 6'd5; tbl[4].rtag = 20'hABCDE;
    tbl[4].exp_hit = 2'b10; tbl[4].exp_valid = 2'b10;
    tbl[5] = wr_vec(6'd5, 2'b11, 20'h55555, 1'b1); tbl[5].raddr = 6'd5; tbl[5].rtag = 20'h55555;
    tbl[5].exp_hit = 2'b11; tbl[5].exp_valid = 2'b11;
    tbl[6] = wr_vec(6'd9, 2'b00, 20'h00000, 1'b1); tbl[6].raddr = 6'd9; tbl[6].rtag = 20'h12345;
    tbl[6].exp_hit = 2'b01; tbl[6].exp_valid = 2'b01;
    tbl[7] = rd_vec(6'd63, 20'h00000); tbl[7].exp_hit = 2'b00; tbl[7].exp_valid = 2'b00;

    // Reset: outputs zero, busy high, before any clock edge.
    #2 rstn = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_hit_any", 64'(hit_any), 64'd0);
    chk("rst_rd_tag", 64'(rd_tag), 64'd0);
    model_clear();
    m_left = SETS;
    @(negedge clk) rstn = 1'b1;
    run_sweep(-1, cyc);
    chk("init_sweep_len", 64'(cyc), 64'd64);
    step(rd_vec(6'd17, 20'h00000));
    chk("post_init_valid", 64'(rd_valid), 64'd0);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i]);
      chk($sformatf("tbl%0d_hit", i), 64'(hit), 64'(tbl[i].exp_hit));
      chk($sformatf("tbl%0d_valid", i), 64'(rd_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_hit_any", i), 64'(hit_any), 64'(|tbl[i].exp_hit));
    end

    // Fill sets 0 and 63, invalidate-all, writes during the sweep are dropped.
    step(wr_vec(6'd0, 2'b11, 20'h11111, 1'b1));
    step(wr_vec(6'd63, 2'b11, 20'h22222, 1'b1));
    step(rd_vec(6'd63, 20'h22222));
    chk("fill_hit", 64'(hit), 64'd3);
    v = idle_vec(); v.inv = 1'b1;
    step(v);
    run_sweep(-1, cyc);
    chk("clear_sweep_len", 64'(cyc), 64'd64);
    step(rd_vec(6'd0, 20'h11111));
    chk("clr_set0_valid", 64'(rd_valid), 64'd0);
    step(rd_vec(6'd63, 20'h22222));
    chk("clr_set63_hit_any", 64'(hit_any), 64'd0);
    step(rd_vec(6'd7, 20'h0BEEF));
    chk("dropped_write", 64'(rd_valid), 64'd0);

    // Re-pulse at sweep cycle 30 is ignored.
    v = idle_vec(); v.inv = 1'b1;
    step(v);
    run_sweep(29, cyc);
    chk("repulse_sweep_len", 64'(cyc), 64'd64);

    // Same-cycle write and invalidate: the write lands, then gets cleared.
    v = wr_vec(6'd3, 2'b01, 20'h33333, 1'b1); v.inv = 1'b1; v.raddr = 6'd3; v.rtag = 20'h33333;
    step(v);
    run_sweep(-1, cyc);
    step(rd_vec(6'd3, 20'h33333));
    chk("wr_inv_cleared", 64'(rd_valid), 64'd0);

    // Reset in the middle of a CLEAR sweep.
    step(wr_vec(6'd1, 2'b10, 20'h44444, 1'b1));
    v = idle_vec(); v.inv = 1'b1;
    step(v);
    for (int i = 0; i < 19; i++) step(idle_vec());
    step(rd_vec(6'd1, 20'h44444));
    #2 rstn = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd1);
    chk("midrst_rd_tag", 64'(rd_tag), 64'd0);
    chk("midrst_hit_any", 64'(hit_any), 64'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_busy", 64'(busy), 64'd1);
    model_clear();
    m_left = SETS;
    @(negedge clk) rstn = 1'b1;
    run_sweep(-1, cyc);
    chk("midrst_sweep_len", 64'(cyc), 64'd64);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      v.we     = 1'($urandom_range(0, 1));
      v.waddr  = pick_addr();
      v.wway   = 2'($urandom_range(0, 3));
      v.wtag   = pick_tag();
      v.wvalid = ($urandom_range(0, 3) != 0);
      v.raddr  = pick_addr();
      v.rtag   = pick_tag();
      v.inv    = ($urandom_range(0, 79) == 0);
      step(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_tagv_array.md
CACHE_TAGV_ARRAY -- requirements
Module: cache_tagv_array

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 20, tag bits per way.
REQ-002 SHALL have parameter INDEX_WIDTH, default 6, set index bits; SETS = 2^INDEX_WIDTH.
REQ-003 SHALL have parameter WAYS, default 2, number of ways (1..8).
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port raddr  in  INDEX_WIDTH  read set index.
REQ-007 SHALL have port rtag  in  TAG_WIDTH  lookup tag, sampled with raddr.
REQ-008 SHALL have port we  in  1  write enable.
REQ-009 SHALL have port waddr  in  INDEX_WIDTH  write set index.
REQ-010 SHALL have port wway  in  WAYS  one-hot (or multi-hot) way select.
REQ-011 SHALL have port wtag  in  TAG_WIDTH  tag to write.
REQ-012 SHALL have port wvalid  in  1  valid bit to write.
REQ-013 SHALL have port inv_req  in  1  pulse: invalidate all sets, all ways (ibar).
REQ-014 SHALL have port busy  out  1  sweep in progress.
REQ-015 SHALL have port rd_tag  out  WAYS*TAG_WIDTH  stored tags, way w at bits [w*TAG_WIDTH +: TAG_WIDTH].
REQ-016 SHALL have port rd_valid  out  WAYS  stored valid bits.
REQ-017 SHALL have port hit  out  WAYS  per-way rd_valid[w] AND tag match with registered rtag.
REQ-018 SHALL have port hit_any  out  1  OR of hit.

Function
REQ-019 Tag and valid bits SHALL be held in per-way RAM arrays without reset (block-RAM inferable); contents SHALL be made defined only by the sweep.
REQ-020 Read latency SHALL be 1 cycle: raddr/rtag registered at edge N; rd_tag/rd_valid/hit valid after edge N, held until next edge.
REQ-021 Write SHALL occur at edge when we=1 and busy=0, to every way w with wway[w]=1; wway=0 SHALL write nothing.
REQ-022 Same-cycle we with waddr==raddr SHALL be write-first: next-cycle outputs of written ways show wtag/wvalid; unwritten ways show old contents.
REQ-023 Hit compare SHALL be combinational on registered RAM output vs registered rtag, full TAG_WIDTH equality.
REQ-024 FSM states: INIT, IDLE, CLEAR.
REQ-025 INIT: entered on reset; sweeps counter cnt from 0 to SETS-1, one set per cycle, writing valid=0, tag=0 in all ways; after cnt==SETS-1 clear -> IDLE.
REQ-026 IDLE: inv_req=1 -> CLEAR next edge with cnt=0; otherwise stay.
REQ-027 CLEAR: identical sweep to INIT; after cnt==SETS-1 -> IDLE.
REQ-028 Sweep SHALL take exactly SETS cycles; busy=1 in INIT and CLEAR, 0 in IDLE.
REQ-029 inv_req while busy SHALL be ignored (no restart, no queueing).
REQ-030 we while busy SHALL be dropped, not deferred.
REQ-031 While busy, or in the cycle after busy falls if the read was issued during busy, hit and rd_valid SHALL read 0.
REQ-032 inv_req and we in the same IDLE cycle: the write SHALL complete, then the sweep SHALL clear it.
REQ-033 cnt SHALL be INDEX_WIDTH bits, wrap unused (sweep terminates at SETS-1).

Reset
REQ-034 rstn=0 SHALL asynchronously force state=INIT, cnt=0, busy=1, read registers 0, hence rd_valid=0, hit=0, hit_any=0, rd_tag=0.
REQ-035 Reset asserted mid-sweep or mid-write SHALL restart INIT from cnt=0; in-flight write may be lost.
REQ-036 After rstn rises, busy SHALL deassert exactly SETS cycles later (64 at defaults).

Verification
REQ-037 Reset release -> busy=1 for 64 cycles, then 0; read any set -> rd_valid=0, hit_any=0.
REQ-038 Write waddr=5, wway=2'b10, wtag=0xABCDE, wvalid=1; next cycle read raddr=5, rtag=0xABCDE -> hit=2'b10, hit_any=1, way0 rd_valid=0.
REQ-039 Same cycle we to set 9 way0 tag 0x12345 and raddr=9, rtag=0x12345 -> next cycle hit=2'b01 (write-first).
REQ-040 Fill sets 0 and 63 both ways, pulse inv_req -> busy 64 cycles; we during sweep dropped; afterwards all reads rd_valid=0.
REQ-041 inv_req re-pulsed at sweep cycle 30 -> sweep still ends at cycle 64, not 94.
REQ-042 rstn pulsed low at CLEAR cycle 20 -> outputs zero immediately; busy for a full 64 cycles after release.
